// File: rtl/gs_rank_extract_pkg.sv
// ============================================================================
// Module  : gs_rank_extract_pkg
// Brief   : Shared sizing defaults, width helper and FSM encoding for the
//           rank-extraction block.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package gs_rank_extract_pkg;

    // Matrix geometry defaults (row width l, row count k, block depth d).
    localparam int GS_L = 8;
    localparam int GS_K = 4;
    localparam int GS_D = 4;

    localparam int GS_DAT_W = GS_L;
    localparam int GS_DAT_D = ((GS_K + GS_D - 1) / GS_D) * GS_D;

    // Ceiling log2, never less than 1 so every derived port has a real bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } gs_state_t;

endpackage

`default_nettype wire

// File: rtl/gs_pivot_enc.sv
// ============================================================================
// Module  : gs_pivot_enc
// Brief   : MSB priority encoder; returns the index of the highest set bit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module gs_pivot_enc #(
    parameter int DAT_W = 8,
    parameter int PIV_W = 3
) (
    input  logic [DAT_W-1:0] row_i,
    output logic [PIV_W-1:0] pivot_o
);

    // Ascending scan so the highest set bit is the last one to win.
    always_comb begin
        pivot_o = '0;
        for (int i = 0; i < DAT_W; i++) begin
            if (row_i[i]) begin
                pivot_o = PIV_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gs_rank_extract.sv
// ============================================================================
// Module  : gs_rank_extract
// Brief   : Scans an eliminated matrix row by row, emits nonzero rows and
//           counts the rank. Macro GS_PIVOT_MAP_EN enables the pivot output.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module gs_rank_extract
    import gs_rank_extract_pkg::*;
#(
    parameter int DAT_W = GS_DAT_W,
    parameter int DAT_D = GS_DAT_D
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         finish,
    output logic [clog2(DAT_D)-1:0]      mem_addr,
    output logic                         mem_rw,
    input  logic [DAT_W-1:0]             mem_din,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DAT_W-1:0]             out_data,
    output logic [clog2(DAT_W)-1:0]      out_pivot,
    output logic [clog2(DAT_D+1)-1:0]    rank
);

    localparam int AW = clog2(DAT_D);
    localparam int PW = clog2(DAT_W);
    localparam int RW = clog2(DAT_D + 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(DAT_D - 1);

    gs_state_t           state_q;
    logic [AW-1:0]       row_cnt_q;
    logic [AW-1:0]       mem_addr_q;
    logic [DAT_W-1:0]    row_q;
    logic [RW-1:0]       rank_q;
    logic                busy_q;
    logic                finish_q;
    logic                out_valid_q;

    logic                w_last_row;
    logic [AW-1:0]       row_cnt_d;

    assign w_last_row = (row_cnt_q == LAST_ROW);
    assign row_cnt_d  = row_cnt_q + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            mem_addr_q  <= '0;
            row_q       <= '0;
            rank_q      <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_ISSUE;
                        row_cnt_q  <= '0;
                        mem_addr_q <= '0;
                        rank_q     <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    state_q <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    row_q <= mem_din;
                    if (|mem_din) begin
                        // At most DAT_D increments per scan, so rank cannot wrap.
                        rank_q      <= rank_q + RW'(1);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else if (w_last_row) begin
                        state_q <= ST_DONE;
                    end else begin
                        row_cnt_q  <= row_cnt_d;
                        mem_addr_q <= row_cnt_d;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (w_last_row) begin
                            state_q <= ST_DONE;
                        end else begin
                            row_cnt_q  <= row_cnt_d;
                            mem_addr_q <= row_cnt_d;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    finish_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign finish    = finish_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rw    = 1'b0;
    assign out_valid = out_valid_q;
    assign out_data  = row_q;
    assign rank      = rank_q;

`ifdef GS_PIVOT_MAP_EN
    gs_pivot_enc #(
        .DAT_W (DAT_W),
        .PIV_W (PW)
    ) u_pivot_enc (
        .row_i   (row_q),
        .pivot_o (out_pivot)
    );
`else
    assign out_pivot = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gs_rank_extract.sv
// ============================================================================
// Module  : tb_gs_rank_extract
// Brief   : Scoreboard bench for gs_rank_extract with a 2-cycle memory model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_gs_rank_extract;
    import gs_rank_extract_pkg::*;

    localparam int DW = 8;
    localparam int DD = 4;
    localparam int AW = clog2(DD);
    localparam int PW = clog2(DW);
    localparam int RW = clog2(DD + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            out_ready = 1'b1;
    logic            busy, finish, mem_rw, out_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   out_data;
    logic [PW-1:0]   out_pivot;
    logic [RW-1:0]   rank;

    gs_rank_extract #(.DAT_W(DW), .DAT_D(DD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .finish    (finish),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_din   (mem_din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pivot (out_pivot),
        .rank      (rank)
    );

    always #5 clk = ~clk;

    // Registered memory: address sampled, then data one further edge later.
    logic [DW-1:0] mem [DD];
    logic [DW-1:0] mem_s1;
    always @(posedge clk) begin
        mem_s1  <= mem[mem_addr];
        mem_din <= mem_s1;
    end

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    bit stall_mode = 1'b0;
    int stall_cnt = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_piv(input logic [DW-1:0] v);
        logic [PW-1:0] p;
        p = '0;
`ifdef GS_PIVOT_MAP_EN
        for (int i = 0; i < DW; i++) begin
            if (v[i]) p = PW'(i);
        end
`endif
        return p;
    endfunction

    // Output monitor: stability while stalled, pop-and-compare on handshake.
    always @(negedge clk) begin
        exp_t head;
        if (finish) fin_cnt++;
        head = (sbq.size() > 0) ? sbq[0] : exp_t'('x);
        if (out_valid && !out_ready) begin
            chk("stall_hold", 32'({out_data, out_pivot}), 32'(head));
        end
        if (stall_mode) begin
            if (out_valid && !out_ready) begin
                stall_cnt++;
                if (stall_cnt == 5) out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
                stall_cnt = 0;
            end
        end else begin
            out_ready = 1'b1;
            stall_cnt = 0;
        end
        if (out_valid && out_ready) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            chk("emit_row", 32'({out_data, out_pivot}), 32'(head));
        end
    end

    task automatic load(input logic [DW-1:0] r0, r1, r2, r3);
        mem[0] = r0; mem[1] = r1; mem[2] = r2; mem[3] = r3;
    endtask

    task automatic do_scan(input int exp_rank, input int exp_lat, input bit retrig);
        int  n;
        bit  seen;
        int  f0;
        for (int i = 0; i < DD; i++) begin
            if (mem[i] != '0) sbq.push_back({mem[i], exp_piv(mem[i])});
        end
        f0 = fin_cnt;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (retrig && (n == 5 || n == 9)) start = 1'b1;
            if (retrig && (n == 6 || n == 10)) start = 1'b0;
            if (finish) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("finish_seen", 32'(seen), 32'd1);
        if (exp_lat >= 0) chk("finish_cycle", 32'(n - 1), 32'(exp_lat));
        @(negedge clk);
        @(negedge clk);
        chk("finish_pulses", 32'(fin_cnt - f0), 32'd1);
        chk("rank", 32'(rank), 32'(exp_rank));
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("mem_rw", 32'(mem_rw), 32'd0);
    endtask

    initial begin
        int f0;
        load(8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        #12;
        chk("reset_outs", 32'({busy, finish, out_valid, mem_rw, mem_addr, rank, out_data, out_pivot}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic sparse matrix.
        load(8'h81, 8'h00, 8'h24, 8'h00);
        do_scan(2, -1, 1'b0);

        // All-zero matrix: nothing emitted, fixed finish latency.
        load(8'h00, 8'h00, 8'h00, 8'h00);
        do_scan(0, 13, 1'b0);

        // Full-rank matrix with consumer backpressure.
        load(8'hFF, 8'h01, 8'h80, 8'h10);
        stall_mode = 1'b1;
        do_scan(4, -1, 1'b0);
        stall_mode = 1'b0;

        // Extra start pulses during the scan must be ignored.
        load(8'h81, 8'h00, 8'h24, 8'h00);
        do_scan(2, -1, 1'b1);

        // Reset while row 0 is being presented.
        stall_mode = 1'b1;
        sbq.push_back({8'h81, exp_piv(8'h81)});
        f0 = fin_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        chk("emit_reached", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midscan_reset_outs", 32'({busy, finish, out_valid, mem_rw, mem_addr, rank, out_data, out_pivot}), 32'd0);
        sbq.delete();
        stall_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_finish_after_abort", 32'(fin_cnt - f0), 32'd0);
        chk("idle_after_abort", 32'({busy, out_valid}), 32'd0);
        do_scan(2, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gs_rank_extract.md
GS_RANK_EXTRACT -- requirements
Module: gs_rank_extract

Interface
REQ-001 Parameter DAT_W, default `l, matrix row width in bits.
REQ-002 Parameter DAT_D, default ceil(`k/`d)*`d, number of rows held in memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to scan the eliminated matrix.
REQ-006 busy  output  1  high from the cycle after start is accepted until finish.
REQ-007 finish  output  1  one-cycle pulse when the scan is complete.
REQ-008 mem_addr  output  CLOG2(DAT_D)  row address to the shared matrix memory.
REQ-009 mem_rw  output  1  memory direction; tied 0 (read only).
REQ-010 mem_din  input  DAT_W  row data from memory, valid 2 cycles after mem_addr is driven.
REQ-011 out_valid  output  1  a nonzero row is presented.
REQ-012 out_ready  input  1  consumer accepts the row when out_valid and out_ready are both high.
REQ-013 out_data  output  DAT_W  the nonzero row.
REQ-014 out_pivot  output  CLOG2(DAT_W)  index of the highest set bit of out_data (macro-gated, REQ-031).
REQ-015 rank  output  CLOG2(DAT_D+1)  count of nonzero rows; final once finish pulses.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT1, WAIT2, EMIT, DONE.
REQ-017 IDLE: start=1 -> ISSUE with row counter=0 and rank=0; start is ignored in every other state.
REQ-018 ISSUE: drive mem_addr=row counter for 1 cycle -> WAIT1 -> WAIT2; in WAIT2 capture mem_din into the row register.
REQ-019 After WAIT2: a nonzero row goes to EMIT and rank increments by 1; a zero row is skipped.
REQ-020 EMIT: out_valid=1 with out_data/out_pivot stable until out_ready=1; leave on the handshake cycle.
REQ-021 Row advance after a skip or handshake: row counter < DAT_D-1 -> increment, ISSUE; row counter = DAT_D-1 -> DONE (no address wrap).
REQ-022 DONE: finish=1 for exactly 1 cycle, then IDLE; rank holds its value until the next accepted start.
REQ-023 One read outstanding at a time; mem_addr holds its last value outside ISSUE.
REQ-024 Zero-row cost: 3 cycles. All-zero matrix: finish in cycle 3*DAT_D+1, counting the start-sampling edge as cycle 0.
REQ-025 out_valid is never high outside EMIT; out_ready is ignored when out_valid=0.
REQ-026 rank saturates at DAT_D by construction; no overflow path exists.

Reset
REQ-027 rst=1 forces IDLE at once; busy, finish, out_valid, mem_rw, mem_addr, rank, out_data and out_pivot are all 0.
REQ-028 rst mid-scan aborts the scan: the pending row is dropped, no finish is issued, and a fresh start is required.

Configuration
REQ-029 Macro GS_PIVOT_MAP_EN selects the pivot-index output.
REQ-030 With GS_PIVOT_MAP_EN defined: out_pivot = index of the MSB set in out_data, computed combinationally from the row register.
REQ-031 Without GS_PIVOT_MAP_EN: out_pivot is driven 0 and the encoder is not instantiated; all other behaviour is identical.

Structure
REQ-032 DAT_W/DAT_D defaults come from the shared define.v (`l, `k, `d); CLOG2 comes from the shared clog2.v; FSM state encodings are local parameters.
REQ-033 One sub-module, gs_pivot_enc: a DAT_W-input MSB priority encoder, present only under GS_PIVOT_MAP_EN.
REQ-034 The block connects to the same registered memory port arrangement as gs_elim_top and runs after gs_elim_top finish.

Verification
REQ-035 DAT_W=8, DAT_D=4, rows {81,00,24,00} hex, out_ready=1 -> emits 81 (pivot 7) then 24 (pivot 5); rank=2; one finish pulse.
REQ-036 All-zero 4-row matrix -> out_valid never asserts; rank=0; finish in cycle 13.
REQ-037 Rows {FF,01,80,10}, out_ready low 5 cycles on each emit -> out_data held stable; 4 rows emitted in order; rank=4.
REQ-038 start pulsed again during the scan of REQ-035 -> ignored; output sequence and rank unchanged.
REQ-039 rst asserted while emitting row 0 of REQ-035 -> outputs 0 at once, no finish; a new start reproduces REQ-035 exactly.
REQ-040 Build without GS_PIVOT_MAP_EN and rerun REQ-035 -> same data and rank; out_pivot=0 throughout.
